// File: rtl/uart_transmitter_pkg.sv
// Shared helpers for the UART transmit path: counter width sizing.
package uart_transmitter_pkg;

   // Bits needed to hold the values 0..value-1 (minimum 1).
   function automatic int clogb2(input int value);
      int v;
      int w;
      v = value - 1;
      w = 0;
      while (v > 0) begin
         w++;
         v = v >> 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while enabled, pulses bit_end_o on the last cycle.
// Combinational bit_end_o from the registered count; clear wins over enable.
module uart_baud_counter
   import uart_transmitter_pkg::*;
#(
   parameter int BIT_CYCLES = 125
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic bit_end_o
);

   localparam int CW = clogb2(BIT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_end_o = enable_i && !clear_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = bit_end_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART TX (8N1, LSB first) with a one-byte holding register; start bit one cycle after accept.
// ready_o is low while the holding register is full; frames run back-to-back with no idle gap.
module uart_transmitter #(
   parameter int CLK_FREQ_HZ = 115200000,
   parameter int BAUDRATE    = 921600
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] data_i,
   input  logic       data_valid_i,
   output logic       ready_o,
   output logic       txd_o,
   output logic       busy_o
);

   localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUDRATE;

   if (BIT_CYCLES < 2) begin : g_bad_baud
      $error("uart_transmitter: CLK_FREQ_HZ / BAUDRATE must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic [7:0] shift_q, shift_d;
   logic       hold_full_q, hold_full_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       txd_q, txd_d;
   logic       busy_q, busy_d;
   logic       bit_end;
   logic       take;

   uart_baud_counter #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_baud (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clear_i   (state_q == IDLE),
      .enable_i  (state_q != IDLE),
      .bit_end_o (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      txd_d     = txd_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      take      = 1'b0;
      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            take  = hold_full_q;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               txd_d   = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  txd_d     = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (hold_full_q) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase

      // Shifter takes the held byte: enter START with the line driven low.
      if (take) begin
         state_d   = START;
         txd_d     = 1'b0;
         shift_d   = hold_q;
         bit_cnt_d = 3'd0;
      end

      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (take) begin
         hold_full_d = 1'b0;
      end else if (data_valid_i && !hold_full_q) begin
         hold_full_d = 1'b1;
         hold_d      = data_i;
      end

      busy_d = (state_d != IDLE) || hold_full_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         hold_q      <= 8'h00;
         shift_q     <= 8'h00;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= 3'd0;
         txd_q       <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         shift_q     <= shift_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         txd_q       <= txd_d;
         busy_q      <= busy_d;
      end
   end

   assign ready_o = !hold_full_q;
   assign txd_o   = txd_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboarded bench: bytes pushed on accept, decoded by a line receiver and compared on frame end.
module tb_uart_transmitter;

   localparam int BC_A = 16;
   localparam int BC_B = 125;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din_a, din_b;
   logic       dv_a, dv_b;
   logic       rdy_a, txd_a, busy_a;
   logic       rdy_b, txd_b, busy_b;

   int n_tests  = 0;
   int n_fail   = 0;
   int rst_evt  = 0;
   int rx_cnt_a = 0;
   int rx_cnt_b = 0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   always #5 clk = ~clk;

   uart_transmitter #(
      .CLK_FREQ_HZ(16),
      .BAUDRATE   (1)
   ) dut_a (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .data_i      (din_a),
      .data_valid_i(dv_a),
      .ready_o     (rdy_a),
      .txd_o       (txd_a),
      .busy_o      (busy_a)
   );

   uart_transmitter dut_b (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .data_i      (din_b),
      .data_valid_i(dv_b),
      .ready_o     (rdy_b),
      .txd_o       (txd_b),
      .busy_o      (busy_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic txd_of(input int w);
      return (w != 0) ? txd_b : txd_a;
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input int k, input int bc);
      int idx;
      idx = k / bc;
      if (idx == 0) return 1'b0;
      else if (idx <= 8) return b[idx-1];
      else return 1'b1;
   endfunction

   // Samples each bit mid-period; frames cut short by a reset discard their expected byte.
   task automatic rx_loop(input int which, input int bc);
      logic [7:0] b;
      logic [7:0] e;
      logic       st, sp;
      int         ev0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && txd_of(which) === 1'b0) begin
            ev0 = rst_evt;
            repeat (bc / 2) @(negedge clk);
            st = txd_of(which);
            for (int i = 0; i < 8; i++) begin
               repeat (bc) @(negedge clk);
               b[i] = txd_of(which);
            end
            repeat (bc) @(negedge clk);
            sp = txd_of(which);
            if (rst_evt != ev0) begin
               if (which == 0 && exp_a.size() > 0) void'(exp_a.pop_front());
               if (which != 0 && exp_b.size() > 0) void'(exp_b.pop_front());
            end else begin
               chk((which != 0) ? "rxB start bit" : "rxA start bit", {31'd0, st}, 32'd0);
               chk((which != 0) ? "rxB stop bit" : "rxA stop bit", {31'd0, sp}, 32'd1);
               if ((which == 0 ? exp_a.size() : exp_b.size()) == 0) begin
                  chk((which != 0) ? "rxB unexpected frame" : "rxA unexpected frame",
                      {24'd0, b}, 32'hFFFF_FFFF);
               end else begin
                  e = (which == 0) ? exp_a.pop_front() : exp_b.pop_front();
                  chk((which != 0) ? "rxB byte" : "rxA byte", {24'd0, b}, {24'd0, e});
               end
               if (which == 0) rx_cnt_a++;
               else rx_cnt_b++;
            end
         end
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send(input int which, input logic [7:0] b);
      int guard;
      guard = 0;
      if (which == 0) begin din_a = b; dv_a = 1'b1; end
      else begin din_b = b; dv_b = 1'b1; end
      while (((which == 0) ? rdy_a : rdy_b) !== 1'b1 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) chk("send ready timeout", 32'd1, 32'd0);
      else if (which == 0) exp_a.push_back(b);
      else exp_b.push_back(b);
      @(negedge clk);
      if (which == 0) dv_a = 1'b0;
      else dv_b = 1'b0;
   endtask

   task automatic wait_idle(input int which, input int budget);
      int n;
      n = 0;
      while (((which == 0) ? busy_a : busy_b) !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk("idle wait timeout", 32'd1, 32'd0);
      repeat (20) @(negedge clk);
   endtask

   initial begin
      int errs;
      int lowcnt;
      int highcnt;

      rst_n = 1'b0;
      dv_a  = 1'b0;
      dv_b  = 1'b0;
      din_a = 8'h00;
      din_b = 8'h00;
      fork
         rx_loop(0, BC_A);
         rx_loop(1, BC_B);
      join_none
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      errs = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if ({txd_a, rdy_a, busy_a} !== 3'b110) errs++;
         if ({txd_b, rdy_b, busy_b} !== 3'b110) errs++;
      end
      chk("reset idle outputs", errs, 0);

      send(0, 8'h55);
      chk("ready low after accept", {31'd0, rdy_a}, 32'd0);
      errs = 0;
      for (int k = 0; k < 160; k++) begin
         @(negedge clk);
         if (txd_a !== frame_bit(8'h55, k, BC_A)) errs++;
         if (busy_a !== 1'b1) errs++;
      end
      chk("0x55 waveform", errs, 0);
      @(negedge clk);
      chk("0x55 busy fall", {31'd0, busy_a}, 32'd0);
      chk("0x55 line idle", {31'd0, txd_a}, 32'd1);
      chk("0x55 ready", {31'd0, rdy_a}, 32'd1);
      repeat (10) @(negedge clk);

      send(0, 8'hA5);
      errs = 0;
      fork
         send(0, 8'h3C);
         for (int k = 0; k < 320; k++) begin
            @(negedge clk);
            if (txd_a !== ((k < 160) ? frame_bit(8'hA5, k, BC_A)
                                     : frame_bit(8'h3C, k - 160, BC_A))) errs++;
            if (busy_a !== 1'b1) errs++;
         end
      join
      chk("back-to-back waveform", errs, 0);
      @(negedge clk);
      chk("back-to-back busy fall", {31'd0, busy_a}, 32'd0);
      repeat (10) @(negedge clk);

      send(0, 8'h01);
      send(0, 8'h02);
      send(0, 8'h03);
      wait_idle(0, 3000);

      send(0, 8'hF0);
      repeat (73) @(negedge clk);
      chk("pre-reset data bit 3", {31'd0, txd_a}, 32'd0);
      rst_n = 1'b0;
      rst_evt++;
      #1;
      chk("reset txd async", {31'd0, txd_a}, 32'd1);
      chk("reset ready", {31'd0, rdy_a}, 32'd1);
      chk("reset busy", {31'd0, busy_a}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      send(0, 8'h81);
      wait_idle(0, 3000);

      send(1, 8'h00);
      @(negedge clk);
      lowcnt = 0;
      while (txd_b === 1'b0 && lowcnt < 3000) begin
         lowcnt++;
         @(negedge clk);
      end
      chk("default 0x00 low span", lowcnt, 1125);
      highcnt = 0;
      errs = 0;
      while (busy_b === 1'b1 && highcnt < 3000) begin
         if (txd_b !== 1'b1) errs++;
         highcnt++;
         @(negedge clk);
      end
      chk("default stop span", highcnt, 125);
      chk("default stop level", errs, 0);
      repeat (20) @(negedge clk);

      chk("rxA frame count", rx_cnt_a, 7);
      chk("rxB frame count", rx_cnt_b, 1);
      chk("scoreboard A drained", exp_a.size(), 0);
      chk("scoreboard B drained", exp_b.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
